wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter and scoreboard that sits directly upstream of the integer register file.
- Merges two result producers into the register file's single write port:
  - the single-cycle ALU, which is never back-pressured;
  - the long-latency path (load/store unit, FPU-to-int moves), which uses valid/ready handshaking.
- Long-latency results are buffered in a small FIFO.
- Tracks registers with outstanding long-latency writes and produces the decode stall for RAW and WAW hazards.

Parameters:
- DATA_WIDTH, 64, register data width
- ADDR_WIDTH, 5, register address width (32 registers)
- FIFO_DEPTH, 4, long-latency result queue entries (power of two, >=2)

Ports:
- in_Clk  input  1  clock
- in_Rst_N  input  1  asynchronous active-low reset
- in_alu_valid  input  1  ALU result present this cycle
- in_alu_addr  input  ADDR_WIDTH  ALU destination register
- in_alu_data  input  DATA_WIDTH  ALU result
- in_mem_valid  input  1  long-latency result offered
- in_mem_addr  input  ADDR_WIDTH  long-latency destination register
- in_mem_data  input  DATA_WIDTH  long-latency result
- out_mem_ready  output  1  long-latency result accepted when high with in_mem_valid
- in_issue_valid  input  1  decode issues a long-latency op this cycle
- in_issue_addr  input  ADDR_WIDTH  its destination register
- in_addr_A, in_addr_B  input  ADDR_WIDTH each  decode source registers
- in_addr_D  input  ADDR_WIDTH  decode destination register
- out_stall  output  1  decode must hold
- out_write_En  output  1  register file write enable
- out_writeAddr  output  ADDR_WIDTH  register file write address
- out_data  output  DATA_WIDTH  register file write data
- out_busy  output  32  scoreboard vector
- out_fifo_count  output  clog2(FIFO_DEPTH)+1  queue occupancy
- out_conflict_cnt  output  32  performance counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low):
  - out_write_En, out_writeAddr, out_data = 0.
  - Scoreboard = 0; FIFO emptied; out_fifo_count = 0; out_conflict_cnt = 0.
  - Assertion mid-operation discards queued and in-flight results; no partial write is emitted.
- Write port: out_* is registered, so a selected result appears one cycle after selection.
- Selection each cycle, in strict priority order:
  1. ALU, if in_alu_valid and in_alu_addr!=0.
  2. Otherwise the FIFO head, if FIFO is non-empty.
  3. Otherwise an accepted mem input bypasses the FIFO (latency 1).
  4. Otherwise out_write_En=0 on the next cycle.
- FIFO push: an accepted mem input that is not bypassed is pushed. Push and pop in the same cycle are legal; the count is unchanged.
- out_mem_ready = (count < FIFO_DEPTH). It is combinational from the count only, with no dependence on in_mem_valid.
  - When full, ready=0 even if a pop happens that cycle.
- Writes to x0 (ALU or mem) are accepted and dropped: no FIFO entry, no output write.
- The ALU never stalls. The FIFO drains only in cycles with no ALU write to a nonzero register.
- Scoreboard:
  - in_issue_valid with addr!=0 sets busy[addr].
  - busy[addr] clears on the clock edge at which the register file captures a mem-sourced write, i.e. at the edge ending the cycle in which out_write_En is high with a mem source. This is required because the register file has no write-through.
  - Set and clear on the same address in the same edge: set wins.
- Stall: out_stall = (A!=0 & busy[A]) | (B!=0 & busy[B]) | (D!=0 & busy[D]).
  - Combinational from the registered scoreboard.
  - The D term prevents WAW hazards and double issue to a busy register.
- Arithmetic: the count is width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: WB_ARB_PERF_CNT_EN.
- Defined: out_conflict_cnt increments by 1 each cycle in which the FIFO is non-empty and an ALU write to a nonzero register is selected. Saturates at 2^32-1.
- Undefined: no counter logic; out_conflict_cnt is tied to 0.

Decomposition:
- Package wb_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS=32;
  - the write-source enumeration SRC_NONE/SRC_ALU/SRC_MEM, which is registered alongside out_* to drive the scoreboard clear.
- Sub-module wb_fifo: synchronous FIFO (DEPTH, WIDTH=ADDR_WIDTH+DATA_WIDTH) with push/pop, count, full/empty, and the same asynchronous reset.

Test Plan:
- ALU valid addr=5 data=0x11 -> next cycle out_write_En=1, out_writeAddr=5, out_data=0x11; two cycles later out_write_En=0.
- Idle arbiter, mem valid addr=7 data=0xAA -> bypass, out_write_En=1 addr=7 the next cycle, FIFO count stays 0.
- ALU valid every cycle for 6 cycles plus 5 mem offers:
  - 4 accepted, then out_mem_ready=0;
  - after the ALU stops, 4 writes drain in FIFO order on consecutive cycles, then the 5th is accepted;
  - out_conflict_cnt counts the blocked cycles when the macro is defined, else reads 0.
- Issue addr=9, decode A=9 -> out_stall=1 until the edge after the mem write to 9 appears on out_*; the next cycle has stall=0. Issue and clear of 9 on the same edge -> busy[9] stays 1.
- Writes to x0 from ALU and mem, and issue to x0 -> no out_write_En, busy stays 0, out_stall=0 with A=B=D=0.
- FIFO holding 3 entries plus busy bits set, assert in_Rst_N=0 asynchronously mid-cycle:
  - all outputs, count and busy are 0 immediately;
  - after release, no stale write is emitted.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the write-source tag for the writeback arbiter.
// The source tag rides alongside the registered write port to drive scoreboard clears.
package wb_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_MEM  = 2'd2
    } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// Purpose: synchronous FIFO holding long-latency writeback results.
// Latency: pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is ignored when full and pop when empty; callers gate on full/empty.
module wb_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 69,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Purpose: merges ALU and long-latency results onto the regfile write port; scoreboard + decode stall.
// Latency: one cycle from selection to out_*; mem bypass when idle, else queued. Optional WB_ARB_PERF_CNT_EN.
// Backpressure: ALU never stalled; out_mem_ready drops only when the result queue is full.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int  DATA_WIDTH = wb_pkg::DATA_WIDTH,
    parameter int  ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
    parameter int  FIFO_DEPTH = 4,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  in_Clk,
    input  logic                  in_Rst_N,
    input  logic                  in_alu_valid,
    input  logic [ADDR_WIDTH-1:0] in_alu_addr,
    input  logic [DATA_WIDTH-1:0] in_alu_data,
    input  logic                  in_mem_valid,
    input  logic [ADDR_WIDTH-1:0] in_mem_addr,
    input  logic [DATA_WIDTH-1:0] in_mem_data,
    output logic                  out_mem_ready,
    input  logic                  in_issue_valid,
    input  logic [ADDR_WIDTH-1:0] in_issue_addr,
    input  logic [ADDR_WIDTH-1:0] in_addr_A,
    input  logic [ADDR_WIDTH-1:0] in_addr_B,
    input  logic [ADDR_WIDTH-1:0] in_addr_D,
    output logic                  out_stall,
    output logic                  out_write_En,
    output logic [ADDR_WIDTH-1:0] out_writeAddr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_REGS-1:0]   out_busy,
    output logic [CW-1:0]         out_fifo_count,
    output logic [31:0]           out_conflict_cnt
);
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;
    logic            alu_sel;
    logic            mem_acc;
    logic            sel_fifo;
    logic            sel_byp;
    logic            fifo_push;
    wb_src_e         wr_src;
    wb_src_e         nxt_src;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   clr_vec;

    assign out_mem_ready = !fifo_full;
    assign alu_sel       = in_alu_valid && (in_alu_addr != '0);
    assign mem_acc       = in_mem_valid && out_mem_ready && (in_mem_addr != '0);
    assign sel_fifo      = !alu_sel && !fifo_empty;
    assign sel_byp       = !alu_sel && fifo_empty && mem_acc;
    assign fifo_push     = mem_acc && !sel_byp;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (in_Clk),
        .rst_n    (in_Rst_N),
        .push     (fifo_push),
        .push_dat ({in_mem_addr, in_mem_data}),
        .pop      (sel_fifo),
        .pop_dat  (fifo_head),
        .count    (out_fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        nxt_src  = SRC_NONE;
        nxt_addr = out_writeAddr;
        nxt_data = out_data;
        if (alu_sel) begin
            nxt_src  = SRC_ALU;
            nxt_addr = in_alu_addr;
            nxt_data = in_alu_data;
        end else if (sel_fifo) begin
            nxt_src  = SRC_MEM;
            nxt_addr = fifo_head[EW-1:DATA_WIDTH];
            nxt_data = fifo_head[DATA_WIDTH-1:0];
        end else if (sel_byp) begin
            nxt_src  = SRC_MEM;
            nxt_addr = in_mem_addr;
            nxt_data = in_mem_data;
        end
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            out_write_En  <= 1'b0;
            out_writeAddr <= '0;
            out_data      <= '0;
            wr_src        <= SRC_NONE;
        end else begin
            out_write_En  <= (nxt_src != SRC_NONE);
            out_writeAddr <= nxt_addr;
            out_data      <= nxt_data;
            wr_src        <= nxt_src;
        end
    end

    // Clear lands on the edge the regfile captures the write; a same-edge issue re-sets the bit.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (in_issue_valid && (in_issue_addr != '0)) set_vec[in_issue_addr] = 1'b1;
        if (out_write_En && (wr_src == SRC_MEM))     clr_vec[out_writeAddr] = 1'b1;
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) busy <= '0;
        else           busy <= (busy & ~clr_vec) | set_vec;
    end

    assign out_busy  = busy;
    assign out_stall = ((in_addr_A != '0) && busy[in_addr_A]) ||
                       ((in_addr_B != '0) && busy[in_addr_B]) ||
                       ((in_addr_D != '0) && busy[in_addr_D]);

`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N)                                        conflict_cnt <= '0;
        else if (alu_sel && !fifo_empty && (conflict_cnt != '1)) conflict_cnt <= conflict_cnt + 1'b1;
    end

    assign out_conflict_cnt = conflict_cnt;
`else
    assign out_conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand sequences for queue fill and reset, then random vs a queue model.
// Expected conflict count follows WB_ARB_PERF_CNT_EN.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_addr, mem_addr, issue_addr, addr_a, addr_b, addr_d;
    logic [63:0] alu_data, mem_data;
    logic        mem_ready, stall, write_en;
    logic [4:0]  write_addr;
    logic [63:0] wdata;
    logic [31:0] busy, conflict_cnt;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .in_Clk(clk), .in_Rst_N(rst_n),
        .in_alu_valid(alu_valid), .in_alu_addr(alu_addr), .in_alu_data(alu_data),
        .in_mem_valid(mem_valid), .in_mem_addr(mem_addr), .in_mem_data(mem_data),
        .out_mem_ready(mem_ready),
        .in_issue_valid(issue_valid), .in_issue_addr(issue_addr),
        .in_addr_A(addr_a), .in_addr_B(addr_b), .in_addr_D(addr_d),
        .out_stall(stall), .out_write_En(write_en), .out_writeAddr(write_addr),
        .out_data(wdata), .out_busy(busy), .out_fifo_count(fifo_count),
        .out_conflict_cnt(conflict_cnt)
    );

    typedef struct {
        logic av; logic [4:0] aa; logic [63:0] ad;
        logic mv; logic [4:0] ma; logic [63:0] md;
        logic iv; logic [4:0] ia;
        logic [4:0] a; logic [4:0] b; logic [4:0] d;
        logic x_rdy; logic x_stall; logic x_en;
        logic [4:0] x_addr; logic [63:0] x_data;
        int x_cnt; logic [31:0] x_busy;
    } vec_t;

    typedef struct packed { logic [4:0] a; logic [63:0] d; } ent_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        issue_valid = 0; issue_addr = 0;
        addr_a = 0; addr_b = 0; addr_d = 0;
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                                input logic mv, input logic [4:0] ma, input logic [63:0] md,
                                input logic iv, input logic [4:0] ia,
                                input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input logic xr, input logic xs, input logic xe,
                                input logic [4:0] xa, input logic [63:0] xd,
                                input int xc, input logic [31:0] xb);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.iv = iv; v.ia = ia; v.a = a; v.b = b; v.d = d;
        v.x_rdy = xr; v.x_stall = xs; v.x_en = xe; v.x_addr = xa; v.x_data = xd;
        v.x_cnt = xc; v.x_busy = xb;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] b9;
        logic [31:0] exp_conf;
        int          k;
        logic        acc, exp_rdy;
        int          blk_cnt [11];
        // random-phase model state
        ent_t        q [$];
        ent_t        e;
        logic [31:0] m_busy;
        logic        m_en, m_src_mem, m_stall, alu_nz;
        logic [4:0]  m_addr;
        logic [63:0] m_data;
        logic [31:0] m_conf;
        int          qsz;

        b9 = 32'h200;
`ifdef WB_ARB_PERF_CNT_EN
        exp_conf = 32'd5;
`else
        exp_conf = 32'd0;
`endif
        //            av aa ad      mv ma md      iv ia  A  B  D   rdy st en xa xd     cnt busy
        vecs[0]  = mk(1, 5, 'h11,   0, 0, 0,      0, 0,  0, 0, 0,  1, 0, 1, 5, 'h11,  0, 0);
        vecs[1]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  0, 0, 0,  1, 0, 0, 0, 0,     0, 0);
        vecs[2]  = mk(0, 0, 0,      1, 7, 'hAA,   0, 0,  0, 0, 0,  1, 0, 1, 7, 'hAA,  0, 0);
        vecs[3]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  0, 0, 0,  1, 0, 0, 0, 0,     0, 0);
        vecs[4]  = mk(1, 0, 'h33,   1, 0, 'h44,   1, 0,  0, 0, 0,  1, 0, 0, 0, 0,     0, 0);
        vecs[5]  = mk(0, 0, 0,      0, 0, 0,      1, 9,  0, 0, 0,  1, 0, 0, 0, 0,     0, b9);
        vecs[6]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  9, 0, 0,  1, 1, 0, 0, 0,     0, b9);
        vecs[7]  = mk(0, 0, 0,      1, 9, 'h99,   0, 0,  9, 0, 0,  1, 1, 1, 9, 'h99,  0, b9);
        vecs[8]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  9, 0, 0,  1, 1, 0, 0, 0,     0, 0);
        vecs[9]  = mk(0, 0, 0,      0, 0, 0,      0, 0,  9, 0, 0,  1, 0, 0, 0, 0,     0, 0);
        vecs[10] = mk(0, 0, 0,      0, 0, 0,      1, 9,  0, 0, 0,  1, 0, 0, 0, 0,     0, b9);
        vecs[11] = mk(0, 0, 0,      1, 9, 'h5,    0, 0,  0, 0, 0,  1, 0, 1, 9, 'h5,   0, b9);
        vecs[12] = mk(0, 0, 0,      0, 0, 0,      1, 9,  0, 0, 0,  1, 0, 0, 0, 0,     0, b9);
        vecs[13] = mk(0, 0, 0,      0, 0, 0,      0, 0,  0, 9, 0,  1, 1, 0, 0, 0,     0, b9);
        vecs[14] = mk(0, 0, 0,      1, 9, 'h7,    0, 0,  0, 0, 9,  1, 1, 1, 9, 'h7,   0, b9);
        vecs[15] = mk(0, 0, 0,      0, 0, 0,      0, 0,  0, 0, 0,  1, 0, 0, 0, 0,     0, 0);
        blk_cnt = '{1, 2, 3, 4, 4, 4, 3, 3, 2, 1, 0};

        rst_n = 0;
        clear_in();
        #2;
        chk("reset_en", write_en, 0);
        chk("reset_addr", write_addr, 0);
        chk("reset_data", wdata, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_conflict", conflict_cnt, 0);
        chk("reset_ready", mem_ready, 1);
        #10 rst_n = 1;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            issue_valid = vecs[i].iv; issue_addr = vecs[i].ia;
            addr_a = vecs[i].a; addr_b = vecs[i].b; addr_d = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_ready", i), mem_ready, vecs[i].x_rdy);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].x_stall);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_en", i), write_en, vecs[i].x_en);
            if (vecs[i].x_en) begin
                chk($sformatf("vec%0d_addr", i), write_addr, vecs[i].x_addr);
                chk($sformatf("vec%0d_data", i), wdata, vecs[i].x_data);
            end
            chk($sformatf("vec%0d_count", i), fifo_count, 64'(vecs[i].x_cnt));
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].x_busy);
        end

        // ALU hogs the port for 6 cycles while 5 mem results are offered
        k = 1;
        for (int c = 0; c <= 10; c++) begin
            clear_in();
            if (c < 6) begin alu_valid = 1; alu_addr = 5'(10 + c); alu_data = 64'h1000 + 64'(c); end
            if (k <= 5) begin mem_valid = 1; mem_addr = 5'(20 + k); mem_data = 64'h100 + 64'(k); end
            exp_rdy = (c < 4) || (c >= 7);
            acc = mem_valid && exp_rdy;
            #1;
            chk($sformatf("blk%0d_ready", c), mem_ready, exp_rdy);
            @(posedge clk); #1;
            if (acc) k++;
            chk($sformatf("blk%0d_en", c), write_en, 1);
            chk($sformatf("blk%0d_addr", c), write_addr, (c < 6) ? 64'(10 + c) : 64'(20 + c - 5));
            chk($sformatf("blk%0d_data", c), wdata, (c < 6) ? 64'h1000 + 64'(c) : 64'h100 + 64'(c - 5));
            chk($sformatf("blk%0d_count", c), fifo_count, 64'(blk_cnt[c]));
        end
        clear_in();
        @(posedge clk); #1;
        chk("blk_idle_en", write_en, 0);
        chk("blk_conflict", conflict_cnt, exp_conf);

        // Fill queue with 3 entries plus busy bits, then reset mid-cycle
        for (int c = 0; c < 3; c++) begin
            clear_in();
            alu_valid = 1; alu_addr = 5'd3; alu_data = 64'hDEAD;
            mem_valid = 1; mem_addr = 5'(12 + c); mem_data = 64'h500 + 64'(c);
            issue_valid = 1; issue_addr = 5'(12 + c);
            @(posedge clk); #1;
        end
        clear_in();
        alu_valid = 1; alu_addr = 5'd3; alu_data = 64'hBEEF;
        chk("rst_pre_count", fifo_count, 3);
        chk("rst_pre_busy", busy, 32'h0000_7000);
        #3 rst_n = 0;
        #1;
        chk("rst_async_en", write_en, 0);
        chk("rst_async_addr", write_addr, 0);
        chk("rst_async_data", wdata, 0);
        chk("rst_async_count", fifo_count, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_conflict", conflict_cnt, 0);
        chk("rst_async_stall", stall, 0);
        clear_in();
        #10 rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_post%0d_en", c), write_en, 0);
            chk($sformatf("rst_post%0d_count", c), fifo_count, 0);
        end

        // Random traffic against a queue-level model
        q.delete();
        m_busy = 0; m_en = 0; m_src_mem = 0; m_addr = 0; m_data = 0; m_conf = 0;
        for (int n = 0; n < 500; n++) begin
            alu_valid   = ($urandom_range(0, 9) < 6);
            alu_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            alu_data    = {$urandom, $urandom};
            mem_valid   = ($urandom_range(0, 1) == 1);
            mem_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mem_data    = {$urandom, $urandom};
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_addr  = 5'($urandom);
            addr_a = 5'($urandom); addr_b = 5'($urandom); addr_d = 5'($urandom);

            qsz     = q.size();
            exp_rdy = (qsz < DEPTH);
            m_stall = ((addr_a != 0) && m_busy[addr_a]) || ((addr_b != 0) && m_busy[addr_b]) ||
                      ((addr_d != 0) && m_busy[addr_d]);
            #1;
            chk("rnd_ready", mem_ready, exp_rdy);
            chk("rnd_stall", stall, m_stall);

            if (m_en && m_src_mem) m_busy[m_addr] = 1'b0;
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            acc    = mem_valid && exp_rdy && (mem_addr != 0);
            alu_nz = alu_valid && (alu_addr != 0);
            m_en = 1; m_src_mem = 1;
            if (alu_nz) begin
                m_src_mem = 0; m_addr = alu_addr; m_data = alu_data;
                if (qsz > 0) m_conf++;
                if (acc) q.push_back('{mem_addr, mem_data});
            end else if (qsz > 0) begin
                e = q.pop_front();
                m_addr = e.a; m_data = e.d;
                if (acc) q.push_back('{mem_addr, mem_data});
            end else if (acc) begin
                m_addr = mem_addr; m_data = mem_data;
            end else begin
                m_en = 0; m_src_mem = 0;
            end

            @(posedge clk); #1;
            chk("rnd_en", write_en, m_en);
            if (m_en) begin
                chk("rnd_addr", write_addr, m_addr);
                chk("rnd_data", wdata, m_data);
            end
            chk("rnd_count", fifo_count, 64'(q.size()));
            chk("rnd_busy", busy, m_busy);
`ifdef WB_ARB_PERF_CNT_EN
            chk("rnd_conflict", conflict_cnt, m_conf);
`else
            chk("rnd_conflict", conflict_cnt, 0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
